fetch_ctrl: RTL and testbench

Instruction fetch controller at the consumer end of the program-counter interface. Drives the PC command pair (`loadPC`/`incPC`) and load `address`, and reads the PC's `execadd`. Fetches each instruction byte from the single-cycle program ROM and hands it to the decoder over a valid/ready handshake. Sequences fall-through, branch redirection and halt.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC command encoding, HALT opcode.
package cpu_pkg;

  typedef enum logic [2:0] {
    CLR    = 3'd0,
    SETTLE = 3'd1,
    FETCH  = 3'd2,
    MEM    = 3'd3,
    VALID  = 3'd4,
    CMD    = 3'd5,
    HALT   = 3'd6
  } fetch_state_t;

  // {loadPC,incPC} command encoding understood by the program counter
  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic [7:0] DEF_HALT_OP = 8'hFF;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steers the PC, reads the ROM and hands each
// instruction to the decoder over valid/ready; handles branch and halt.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              ADDR_W  = 5,
  parameter int              DATA_W  = 8,
  parameter logic [DATA_W-1:0] HALT_OP = DEF_HALT_OP
) (
  input  logic              clk,
  input  logic              rst,
  output logic              loadPC,
  output logic              incPC,
  output logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] execadd,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  fetch_state_t      r_state;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_target;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_mem_rd;
  logic              r_halted;
  logic              w_accept;

  assign w_accept = r_instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CLR;
      r_cmd         <= PC_CLR;
      r_target      <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        CLR: begin
          r_cmd   <= PC_HOLD;
          r_state <= SETTLE;
        end
        // execadd reflects the last command only from the FETCH cycle onward
        SETTLE: begin
          r_mem_rd <= 1'b1;
          r_state  <= FETCH;
        end
        FETCH: begin
          r_mem_rd <= 1'b0;
          r_state  <= MEM;
        end
        MEM: begin
          r_instr       <= mem_rdata;
          r_instr_pc    <= execadd;
          r_instr_valid <= 1'b1;
          r_state       <= VALID;
        end
        VALID: begin
          if (w_accept) begin
            r_instr_valid <= 1'b0;
            if (r_instr == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else if (branch_req) begin
              r_target <= branch_target;
              r_cmd    <= PC_LOAD;
              r_state  <= CMD;
            end else begin
              r_cmd   <= PC_INC;
              r_state <= CMD;
            end
          end
        end
        CMD: begin
          r_cmd   <= PC_HOLD;
          r_state <= SETTLE;
        end
        HALT: r_state <= HALT;
        default: begin
          r_cmd   <= PC_CLR;
          r_state <= CLR;
        end
      endcase
    end
  end

  assign loadPC      = r_cmd[1];
  assign incPC       = r_cmd[0];
  assign address     = (r_cmd == PC_LOAD) ? r_target : '0;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_rd ? execadd : '0;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a behavioural two-stage PC and a 32x8 ROM.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadPC, incPC;
  logic [4:0] address, execadd, mem_addr, instr_pc, branch_target;
  logic       mem_rd, instr_valid, instr_ready, branch_req, halted;
  logic [7:0] mem_rdata, instr;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .loadPC(loadPC), .incPC(incPC), .address(address),
    .execadd(execadd), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_req(branch_req),
    .branch_target(branch_target), .halted(halted)
  );

  // PC: command registered, then applied, so visible two cycles after issue
  logic [1:0] pc_cmd_q;
  logic [4:0] pc_addr_q;
  always @(posedge clk) begin
    if (rst) begin
      pc_cmd_q  <= 2'b11;
      pc_addr_q <= 5'd0;
      execadd   <= 5'd0;
    end else begin
      pc_cmd_q  <= {loadPC, incPC};
      pc_addr_q <= address;
      case (pc_cmd_q)
        2'b00:   execadd <= 5'd0;
        2'b10:   execadd <= pc_addr_q;
        2'b01:   execadd <= execadd + 5'd1;
        default: execadd <= execadd;
      endcase
    end
  end

  logic [7:0] rom [32];
  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  int cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct { logic [7:0] ins; logic [4:0] pc; int cyc; } exp_t;
  exp_t sb[$];

  // Monitor: every accept pops one expected instruction
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_accept", 32'(instr_pc), 32'hDEAD);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc_instr", 32'(instr), 32'(e.ins));
        chk("acc_pc", 32'(instr_pc), 32'(e.pc));
        if (e.cyc >= 0) chk("acc_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (instr_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // kind: 0 fall-through, 1 branch, 2 halt
  task automatic item(input logic [7:0] ins, input logic [4:0] pc, input int dly,
                      input int kind, input logic [4:0] tgt, input int ecyc);
    bit ok;
    exp_t e;
    wait_valid(ok);
    if (!ok) return;
    for (int k = 0; k < dly; k++) begin
      chk("bp_instr", 32'(instr), 32'(ins));
      chk("bp_pc", 32'(instr_pc), 32'(pc));
      chk("bp_cmd", 32'({loadPC, incPC}), 32'd3);
      chk("bp_mem_rd", 32'(mem_rd), 32'd0);
      @(posedge clk); #1;
    end
    e.ins = ins; e.pc = pc; e.cyc = ecyc;
    sb.push_back(e);
    instr_ready   = 1'b1;
    branch_req    = (kind == 1);
    branch_target = tgt;
    @(posedge clk); #1;
    instr_ready   = 1'b0;
    branch_req    = 1'b0;
    branch_target = 5'h0A;
    if (kind == 1) begin
      chk("br_cmd", 32'({loadPC, incPC}), 32'd2);
      chk("br_address", 32'(address), 32'(tgt));
      @(posedge clk); #1;
      chk("br_cmd_one_cycle", 32'({loadPC, incPC}), 32'd3);
    end else if (kind == 0) begin
      chk("inc_cmd", 32'({loadPC, incPC}), 32'd1);
    end else begin
      chk("halted", 32'(halted), 32'd1);
      chk("halt_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  initial begin
    int bad;
    bit ok;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    rom[4] = 8'hFF; rom[7] = 8'h77; rom[5'h1A] = 8'h55; rom[5'h1F] = 8'h66;
    rst = 1'b1; instr_ready = 1'b0; branch_req = 1'b0; branch_target = 5'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cmd", 32'({loadPC, incPC}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("clr_cmd", 32'({loadPC, incPC}), 32'd0);

    item(8'h11, 5'd0,     0,  0, 5'd0,    4);
    item(8'h22, 5'd1,     0,  0, 5'd0,    9);
    item(8'h33, 5'd2,     10, 0, 5'd0,    24);
    item(8'h44, 5'd3,     0,  1, 5'h1A,   29);
    item(8'h55, 5'h1A,    2,  1, 5'h1F,   -1);
    item(8'h66, 5'h1F,    0,  0, 5'd0,    -1);
    item(8'h11, 5'd0,     0,  0, 5'd0,    -1);
    item(8'h22, 5'd1,     0,  0, 5'd0,    -1);
    item(8'h33, 5'd2,     1,  0, 5'd0,    -1);
    item(8'h44, 5'd3,     0,  0, 5'd0,    -1);
    item(8'hFF, 5'd4,     0,  2, 5'd0,    -1);

    bad = 0;
    instr_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (mem_rd || instr_valid || !halted || {loadPC, incPC} != 2'b11) bad++;
    end
    instr_ready = 1'b0;
    chk("halt_quiet_50", 32'(bad), 32'd0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_clears_halt", 32'(halted), 32'd0);
    item(8'h11, 5'd0, 0, 0, 5'd0, 4);
    item(8'h22, 5'd1, 0, 0, 5'd0, -1);
    item(8'h33, 5'd2, 0, 0, 5'd0, -1);
    item(8'h44, 5'd3, 0, 1, 5'd7, -1);

    wait_valid(ok);
    if (ok) begin
      chk("pre_rst_pc", 32'(instr_pc), 32'd7);
      chk("pre_rst_instr", 32'(instr), 32'h77);
      @(posedge clk); #1;
      instr_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      rst = 1'b0;
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_cmd", 32'({loadPC, incPC}), 32'd0);
    end
    item(8'h11, 5'd0, 0, 0, 5'd0, 4);
    item(8'h22, 5'd1, 0, 0, 5'd0, 9);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
